// File: rtl/pll_lock_mon_pkg.sv
// Shared types and constants for the PLL lock monitor.
package pll_mon_pkg;

    typedef enum logic [2:0] {
        S_RST       = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_FILTER    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    localparam int LOSS_CNT_W = 8;

endpackage

// File: rtl/pll_lock_mon_if.sv
// PLL-side and status signals of the lock monitor.
// The master modport is the monitor's view; slave is the PLL/system side.
interface pll_lock_mon_if;
    import pll_mon_pkg::*;

    logic                  pll_locked_i;
    logic                  clr_i;
    logic                  pll_rst_o;
    logic                  sys_rst_req_o;
    logic                  lock_ok_o;
    logic                  fail_o;
    logic [LOSS_CNT_W-1:0] loss_cnt_o;

    modport master (
        input  pll_locked_i, clr_i,
        output pll_rst_o, sys_rst_req_o, lock_ok_o, fail_o, loss_cnt_o
    );

    modport slave (
        output pll_locked_i, clr_i,
        input  pll_rst_o, sys_rst_req_o, lock_ok_o, fail_o, loss_cnt_o
    );

endinterface

// File: rtl/pll_lock_mon_sync_2ff.sv
// Generic 1-bit two-flop synchronizer; no reset on the data path so it
// can be dropped onto any asynchronous input.
module sync_2ff (
    input  logic clk_i,
    input  logic d_i,
    output logic q_o
);

    logic r_meta;

    always_ff @(posedge clk_i) begin
        r_meta <= d_i;
        q_o    <= r_meta;
    end

endmodule

// File: rtl/pll_lock_mon.sv
// PLL lock monitor: pulses the PLL reset, filters relock, holds the system
// reset request until lock is stable, and retries a bounded number of times.
module pll_lock_mon #(
    parameter int LOCK_FILT_CNT  = 16,
    parameter int PLL_RST_CNT    = 32,
    parameter int RELOCK_TIMEOUT = 4096,
    parameter int MAX_RETRY      = 3,
    parameter int CNT_W          = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    pll_lock_mon_if.master bus
);
    import pll_mon_pkg::*;

    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    logic                  w_lk_s;
    state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_timer, w_timer_nxt;
    logic [RETRY_W-1:0]    r_retry, w_retry_nxt, w_retry_inc;
    logic [LOSS_CNT_W-1:0] r_loss, w_loss_nxt;

    sync_2ff u_sync (
        .clk_i (clk_i),
        .d_i   (bus.pll_locked_i),
        .q_o   (w_lk_s)
    );

    // The WAIT_LOCK cycle that first sees lock counts as the first good sample,
    // so FILTER needs LOCK_FILT_CNT-1 further samples (LOCK_FILT_CNT >= 2).
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer + 1'b1;
        w_retry_nxt = r_retry;
        w_retry_inc = r_retry + 1'b1;
        w_loss_nxt  = r_loss;
        case (r_state)
            S_RST: begin
                if (r_timer == CNT_W'(PLL_RST_CNT - 1)) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_timer_nxt = '0;
                end
            end
            S_WAIT_LOCK: begin
                if (w_lk_s) begin
                    w_state_nxt = S_FILTER;
                    w_timer_nxt = '0;
                end else if (r_timer == CNT_W'(RELOCK_TIMEOUT - 1)) begin
                    w_retry_nxt = w_retry_inc;
                    w_timer_nxt = '0;
                    w_state_nxt = (w_retry_inc == RETRY_W'(MAX_RETRY)) ? S_FAIL : S_RST;
                end
            end
            S_FILTER: begin
                if (!w_lk_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_timer_nxt = '0;
                end else if (w_timer_nxt == CNT_W'(LOCK_FILT_CNT - 1)) begin
                    w_state_nxt = S_RUN;
                    w_timer_nxt = '0;
                    w_retry_nxt = '0;
                end
            end
            S_RUN: begin
                w_timer_nxt = '0;
                if (!w_lk_s) begin
                    w_state_nxt = S_RST;
                    if (r_loss != '1) begin
                        w_loss_nxt = r_loss + 1'b1;
                    end
                end
            end
            S_FAIL: begin
                w_timer_nxt = '0;
            end
            default: begin
                w_state_nxt = S_RST;
                w_timer_nxt = '0;
            end
        endcase
        if (bus.clr_i) begin
            w_state_nxt = S_RST;
            w_timer_nxt = '0;
            w_retry_nxt = '0;
            w_loss_nxt  = '0;
        end
    end

    // Outputs are decoded from the next state so they move on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state           <= S_RST;
            r_timer           <= '0;
            r_retry           <= '0;
            r_loss            <= '0;
            bus.pll_rst_o     <= 1'b1;
            bus.sys_rst_req_o <= 1'b1;
            bus.lock_ok_o     <= 1'b0;
            bus.fail_o        <= 1'b0;
        end else begin
            r_state           <= w_state_nxt;
            r_timer           <= w_timer_nxt;
            r_retry           <= w_retry_nxt;
            r_loss            <= w_loss_nxt;
            bus.pll_rst_o     <= (w_state_nxt == S_RST) || (w_state_nxt == S_FAIL);
            bus.sys_rst_req_o <= (w_state_nxt != S_RUN);
            bus.lock_ok_o     <= (w_state_nxt == S_RUN);
            bus.fail_o        <= (w_state_nxt == S_FAIL);
        end
    end

    assign bus.loss_cnt_o = r_loss;

endmodule

// File: tb/tb_pll_lock_mon.sv
// Self-checking bench for pll_lock_mon: directed scenarios plus random lock
// activity, compared every cycle against a phase/countdown reference model.
module tb_pll_lock_mon;
    import pll_mon_pkg::*;

    localparam int FILT = 4;
    localparam int RSTC = 8;
    localparam int TMO  = 64;
    localparam int MAXR = 2;

    localparam int PH_PULSE = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_FILT  = 2;
    localparam int PH_RUN   = 3;
    localparam int PH_FAIL  = 4;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    pll_lock_mon_if ifc ();

    pll_lock_mon #(
        .LOCK_FILT_CNT  (FILT),
        .PLL_RST_CNT    (RSTC),
        .RELOCK_TIMEOUT (TMO),
        .MAX_RETRY      (MAXR),
        .CNT_W          (16)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (ifc)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    int   mPhase      = PH_PULSE;
    int   mPulseLeft  = RSTC;
    int   mWaitCycles = 0;
    int   mGood       = 0;
    int   mFails      = 0;
    int   mLoss       = 0;
    logic mPipe0      = 1'b0;
    logic mPipe1      = 1'b0;
    bit   modelValid  = 1'b0;

    // Reference model: pulse countdown, wait budget, run of good lock samples.
    always @(posedge clk_i) begin : refModel
        logic lk;
        lk = mPipe1;
        if (rst_i || ifc.clr_i) begin
            mPhase     = PH_PULSE;
            mPulseLeft = RSTC;
            mFails     = 0;
            mLoss      = 0;
        end else begin
            case (mPhase)
                PH_PULSE: begin
                    mPulseLeft--;
                    if (mPulseLeft == 0) begin
                        mPhase      = PH_WAIT;
                        mWaitCycles = 0;
                    end
                end
                PH_WAIT: begin
                    if (lk) begin
                        mPhase = PH_FILT;
                        mGood  = 1;
                    end else begin
                        mWaitCycles++;
                        if (mWaitCycles == TMO) begin
                            mFails++;
                            if (mFails == MAXR) begin
                                mPhase = PH_FAIL;
                            end else begin
                                mPhase     = PH_PULSE;
                                mPulseLeft = RSTC;
                            end
                        end
                    end
                end
                PH_FILT: begin
                    if (!lk) begin
                        mPhase      = PH_WAIT;
                        mWaitCycles = 0;
                    end else begin
                        mGood++;
                        if (mGood == FILT) begin
                            mPhase = PH_RUN;
                            mFails = 0;
                        end
                    end
                end
                PH_RUN: begin
                    if (!lk) begin
                        mPhase     = PH_PULSE;
                        mPulseLeft = RSTC;
                        if (mLoss < 255) mLoss++;
                    end
                end
                default: ;
            endcase
        end
        mPipe1     = mPipe0;
        mPipe0     = ifc.pll_locked_i;
        modelValid = 1'b1;
    end

    always @(negedge clk_i) begin : compare
        logic [11:0] expv;
        logic [11:0] actv;
        if (modelValid) begin
            expv = {(mPhase == PH_PULSE) || (mPhase == PH_FAIL), mPhase != PH_RUN,
                    mPhase == PH_RUN, mPhase == PH_FAIL, 8'(mLoss)};
            actv = {ifc.pll_rst_o, ifc.sys_rst_req_o, ifc.lock_ok_o, ifc.fail_o, ifc.loss_cnt_o};
            total++;
            if (actv !== expv) begin
                bad++;
                $display("[TB] FAIL model_cycle t=%0t got {rst,req,ok,fail,loss}=%h want %h",
                         $time, actv, expv);
            end
        end
    end

    task automatic applyStimulus(input bit r, input bit lk, input bit c);
        rst_i            = r;
        ifc.pll_locked_i = lk;
        ifc.clr_i        = c;
    endtask

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d want %0d", name, actual, expected);
        end
    endtask

    function automatic bit sigVal(input int sel);
        case (sel)
            0:       return ifc.pll_rst_o;
            1:       return ifc.lock_ok_o;
            default: return ifc.fail_o;
        endcase
    endfunction

    task automatic stepsUntil(input int sel, input bit val, input int budget, output int n);
        n = 0;
        while (sigVal(sel) != val && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic pulseWidth(output int n);
        n = 0;
        while (ifc.pll_rst_o && n < 100) begin
            n++;
            step();
        end
    endtask

    initial begin : stimulus
        int n;
        bit lk;
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (3) step();
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Power-up: one clean PLL reset pulse, then relock latency.
        pulseWidth(n);
        checkOutput("pwr_rst_width", n, 8);
        repeat (5) step();
        applyStimulus(1'b0, 1'b1, 1'b0);
        stepsUntil(1, 1'b1, 50, n);
        checkOutput("pwr_lock_latency", n, 6);
        checkOutput("pwr_sys_rst_req", ifc.sys_rst_req_o, 0);
        checkOutput("pwr_loss_cnt", ifc.loss_cnt_o, 0);

        // Loss in RUN for 100 cycles, including one relock timeout.
        applyStimulus(1'b0, 1'b0, 1'b0);
        stepsUntil(0, 1'b1, 50, n);
        checkOutput("loss_rst_latency", n, 3);
        pulseWidth(n);
        checkOutput("loss_rst_width", n, 8);
        repeat (100 - 11) step();
        applyStimulus(1'b0, 1'b1, 1'b0);
        stepsUntil(1, 1'b1, 50, n);
        checkOutput("loss_relock_latency", n, 6);
        checkOutput("loss_cnt_one", ifc.loss_cnt_o, 1);

        // Filter bounce: two good samples, one bad, then a fresh full run.
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (20) step();
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (2) step();
        applyStimulus(1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b1, 1'b0);
        stepsUntil(1, 1'b1, 50, n);
        checkOutput("bounce_latency", n + 3, 9);

        // Lock never returns: two reset+wait rounds, then sticky FAIL.
        applyStimulus(1'b0, 1'b0, 1'b0);
        stepsUntil(2, 1'b1, 400, n);
        checkOutput("fail_latency", n, 147);
        repeat (50) step();
        checkOutput("fail_held", ifc.fail_o, 1);
        checkOutput("fail_pll_rst", ifc.pll_rst_o, 1);
        checkOutput("fail_sys_rst_req", ifc.sys_rst_req_o, 1);

        // Clear from FAIL with lock present.
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (5) step();
        applyStimulus(1'b0, 1'b1, 1'b1);
        step();
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("clr_fail_low", ifc.fail_o, 0);
        pulseWidth(n);
        checkOutput("clr_rst_width", n, 8);
        stepsUntil(1, 1'b1, 50, n);
        checkOutput("clr_lock_latency", n, 4);
        checkOutput("clr_loss_cnt", ifc.loss_cnt_o, 0);

        // Random lock activity with occasional clear and reset.
        lk = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 11) == 0) lk = ~lk;
            applyStimulus($urandom_range(0, 299) == 0, lk, $urandom_range(0, 99) == 0);
            step();
        end

        // Saturation: 300 single-cycle losses from RUN.
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (2) step();
        applyStimulus(1'b0, 1'b1, 1'b0);
        stepsUntil(1, 1'b1, 100, n);
        checkOutput("sat_initial_lock", ifc.lock_ok_o, 1);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            step();
            applyStimulus(1'b0, 1'b1, 1'b0);
            repeat ($urandom_range(16, 24)) step();
        end
        checkOutput("sat_loss_cnt", ifc.loss_cnt_o, 255);

        // Clear lands on the same edge as a loss detection.
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (2) step();
        applyStimulus(1'b0, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("collide_loss_cnt", ifc.loss_cnt_o, 0);
        checkOutput("collide_pll_rst", ifc.pll_rst_o, 1);
        checkOutput("collide_lock_ok", ifc.lock_ok_o, 0);
        repeat (20) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
